// File: rtl/inst_fetch_if.sv
// Fetch-to-decode bus: the registered instruction slot (valid/ready) and the
// downstream redirect request.
//   master : the fetch stage. It drives out_valid/out_inst/out_pc and receives
//            out_ready and the redirect request.
//   slave  : the decode side. It drives out_ready/redirect_valid/redirect_pc.
interface inst_fetch_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    input  out_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output out_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage. It reads the ROM word array at a word-addressed PC
// and registers the fetched word into a valid/ready slot for decode. It stops
// on the HALT_WORD sentinel, and it faults on a fetch at PC >= MEM_DEPTH. A
// downstream redirect flushes the slot and restarts fetch; a redirect also
// recovers the stage from the HALT and FAULT states.
// Ports:
//   clk, rstn    clock (rising edge); synchronous active-low reset
//   mem_inst     ROM contents; element [i] is the word at address i
//   start        begin fetching from PC 0 (sampled only in IDLE)
//   bus          out slot (out_valid/out_ready/out_inst/out_pc) and redirect
//   halted       fetch stopped on HALT_WORD
//   fault        fetch attempted at PC >= MEM_DEPTH
//   fetch_count  completed out handshakes, saturating
module inst_fetch #(
  parameter int unsigned MEM_DEPTH = 200,
  parameter int unsigned PC_WIDTH  = 8,
  parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_inst [MEM_DEPTH],
  input  logic        start,
  inst_fetch_if.master bus,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned         IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                out_valid_q;
  logic [31:0]         out_inst_q;
  logic [PC_WIDTH-1:0] out_pc_q;
  logic                halted_q;
  logic                fault_q;
  logic [31:0]         fetch_count_q;

  logic                free;
  logic                handshake;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         word;

  assign free      = !out_valid_q || bus.out_ready;
  assign handshake = out_valid_q && bus.out_ready;
  assign in_range  = (pc_q <= LAST_PC);
  // 2^PC_WIDTH > MEM_DEPTH guarantees IDX_W <= PC_WIDTH.
  assign idx       = pc_q[IDX_W-1:0];
  // Only index the array when the PC is in range.
  assign word      = in_range ? mem_inst[idx] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      out_valid_q   <= 1'b0;
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      // A handshake in the same cycle as a redirect still counts.
      if (handshake && (fetch_count_q != '1)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= '0;
          end
        end
        default: begin
          if (bus.redirect_valid) begin
            state_q     <= StRun;
            pc_q        <= bus.redirect_pc;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
          end else if ((state_q == StRun) && free) begin
            if (!in_range) begin
              state_q     <= StFault;
              out_valid_q <= 1'b0;
              fault_q     <= 1'b1;
            end else if (word == HALT_WORD) begin
              // The sentinel is not placed in the slot and the PC stays on it.
              state_q     <= StHalt;
              out_valid_q <= 1'b0;
              halted_q    <= 1'b1;
            end else begin
              out_inst_q  <= word;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              pc_q        <= pc_q + PC_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_pc    = out_pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. It runs a directed walk through the main
// scenarios and then a randomized phase. Every cycle is checked against a
// behavioural model that treats the ROM as a program and the output slot as
// one buffered instruction.
module tb_inst_fetch;

  localparam int unsigned MEM_DEPTH = 200;
  localparam int unsigned PC_WIDTH  = 8;
  localparam logic [31:0] HALT_WORD = 32'hffffffff;

  logic        clk;
  logic        rstn;
  logic [31:0] rom [MEM_DEPTH];
  logic        start;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  inst_fetch_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  inst_fetch #(
    .MEM_DEPTH(MEM_DEPTH),
    .PC_WIDTH (PC_WIDTH),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mem_inst   (rom),
    .start      (start),
    .bus        (bus),
    .halted     (halted),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  // m_started : start has been seen since the last reset.
  // m_v       : a fetched instruction is waiting in the slot.
  bit                  m_started;
  logic [PC_WIDTH-1:0] m_pc;
  bit                  m_v;
  logic [31:0]         m_inst;
  logic [PC_WIDTH-1:0] m_opc;
  bit                  m_halt;
  bit                  m_fault;
  logic [31:0]         m_cnt;

  task automatic model_reset();
    m_started = 0; m_pc = '0; m_v = 0; m_inst = '0; m_opc = '0;
    m_halt = 0; m_fault = 0; m_cnt = '0;
  endtask

  // Applies one clock edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    if (!rstn) begin
      model_reset();
      return;
    end
    if (m_v && bus.out_ready && (m_cnt != 32'hffffffff)) m_cnt = m_cnt + 1;
    if (!m_started) begin
      if (start) begin
        m_started = 1;
        m_pc      = '0;
      end
    end else if (bus.redirect_valid) begin
      m_v = 0; m_pc = bus.redirect_pc; m_halt = 0; m_fault = 0;
    end else if (!m_halt && !m_fault && (!m_v || bus.out_ready)) begin
      if (int'(m_pc) >= MEM_DEPTH) begin
        m_v = 0; m_fault = 1;
      end else if (rom[m_pc] == HALT_WORD) begin
        m_v = 0; m_halt = 1;
      end else begin
        m_inst = rom[m_pc]; m_opc = m_pc; m_v = 1; m_pc = m_pc + 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_v});
    if (m_v) begin
      check("out_pc", {24'd0, bus.out_pc}, {24'd0, m_opc});
      check("out_inst", bus.out_inst, m_inst);
    end
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("fault", {31'd0, fault}, {31'd0, m_fault});
    check("fetch_count", fetch_count, m_cnt);
  endtask

  // One clock: model update at the edge, DUT outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic redirect_to(input int unsigned pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = PC_WIDTH'(pc);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT_WORD) w = 32'h0;
      if (i > 50 && $urandom_range(0, 29) == 0) w = HALT_WORD;
      rom[i] = w;
    end
    rom[0]  = 32'h20010003; rom[1]  = 32'hafdf0001; rom[2]  = 32'h23de0002;
    rom[3]  = 32'h0c00000d; rom[11] = 32'h68010000; rom[13] = 32'h201a0000;
    rom[41] = 32'h6c010000; rom[42] = 32'h03e00008; rom[43] = HALT_WORD;

    model_reset();
    rstn = 1'b0; start = 1'b0;
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    #2;
    tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_pc", {24'd0, bus.out_pc}, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // Redirect in IDLE is ignored.
    rstn = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'd13;
    tick();
    bus.redirect_valid = 1'b0;
    check("idle_no_fetch", {31'd0, bus.out_valid}, 32'd0);

    // Start and stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("first_pc", {24'd0, bus.out_pc}, 32'd0);
    check("first_inst", bus.out_inst, 32'h20010003);
    tick();
    check("second_pc", {24'd0, bus.out_pc}, 32'd1);
    check("second_inst", bus.out_inst, 32'hafdf0001);
    tick();
    check("third_pc", {24'd0, bus.out_pc}, 32'd2);

    // Backpressure holds the slot and freezes the count.
    bus.out_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_pc", {24'd0, bus.out_pc}, 32'd2);
      check("bp_inst", bus.out_inst, 32'h23de0002);
      check("bp_count", fetch_count, 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    check("rel_pc", {24'd0, bus.out_pc}, 32'd3);
    check("rel_inst", bus.out_inst, 32'h0c00000d);

    // Redirect flushes the slot, then fetches from the target.
    redirect_to(13);
    check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("redir_pc", {24'd0, bus.out_pc}, 32'd13);
    check("redir_inst", bus.out_inst, 32'h201a0000);

    // Halt on the sentinel, then recover.
    redirect_to(41);
    tick();
    check("h41", bus.out_inst, 32'h6c010000);
    tick();
    check("h42", bus.out_inst, 32'h03e00008);
    tick();
    check("halted_set", {31'd0, halted}, 32'd1);
    check("halt_no_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) tick();
    redirect_to(11);
    check("halt_clear", {31'd0, halted}, 32'd0);
    tick();
    check("rec_pc", {24'd0, bus.out_pc}, 32'd11);
    check("rec_inst", bus.out_inst, 32'h68010000);

    // Fault on an out-of-range PC, then recover.
    redirect_to(200);
    tick();
    check("fault_set", {31'd0, fault}, 32'd1);
    repeat (2) tick();
    check("fault_hold", {31'd0, fault}, 32'd1);
    redirect_to(0);
    check("fault_clear", {31'd0, fault}, 32'd0);
    tick();
    check("fault_rec", bus.out_inst, 32'h20010003);

    // Reset in the middle of a run.
    rstn = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_count", fetch_count, 32'd0);
    rstn = 1'b1;
    repeat (3) tick();
    check("no_restart", {31'd0, bus.out_valid}, 32'd0);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      rstn               = ($urandom_range(0, 199) != 0);
      start              = ($urandom_range(0, 9) == 0);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = PC_WIDTH'($urandom_range(0, 209));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
